// File: rtl/mem_arb.sv
// mem_arb: arbitrates I-cache and D-cache requests onto one main-memory port (IDLE/ISSUE/WAIT/RESP).
// Define MEM_ARB_RR_EN for round-robin on simultaneous requests; otherwise D always wins.
module mem_arb (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [15:0] i_addr,
  output logic        i_done,
  input  logic        d_req,
  input  logic        d_wr,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic        d_done,
  output logic [15:0] rdata,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  output logic        busy
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;
  logic [1:0]  state_q, state_d;
  logic        owner_q, owner_d;
  logic        wr_q, wr_d;
  logic [15:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic        d_wins;
  logic        grant;
  assign grant = (state_q == IDLE) && (i_req || d_req);
`ifdef MEM_ARB_RR_EN
  // rr_q=1 means D is preferred; it points away from whoever was just granted
  logic rr_q, rr_d;
  assign d_wins = d_req && (!i_req || rr_q);
  always_comb rr_d = grant ? !d_wins : rr_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) rr_q <= 1'b1;
    else      rr_q <= rr_d;
`else
  assign d_wins = d_req;
`endif
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: if (grant) begin
        state_d = ISSUE;
        owner_d = d_wins;
        wr_d    = d_wins && d_wr;
        addr_d  = d_wins ? d_addr : i_addr;
        wdata_d = d_wins ? d_wdata : 16'h0000;
      end
      ISSUE, WAIT: if (mem_ready) begin
        state_d = RESP;
        rdata_d = mem_rdata;
      end else begin
        state_d = WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end
  assign mem_en    = state_q == ISSUE;
  assign busy      = state_q != IDLE;
  assign i_done    = (state_q == RESP) && !owner_q;
  assign d_done    = (state_q == RESP) && owner_q;
  assign mem_wr    = wr_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign rdata     = rdata_q;
endmodule

// File: tb/tb_mem_arb.sv
// tb_mem_arb: directed self-checking bench for mem_arb.
// Build with +define+MEM_ARB_RR_EN to check the round-robin variant.
module tb_mem_arb;
  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_wr, mem_ready;
  logic [15:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic        i_done, d_done, mem_en, mem_wr, busy;
  logic [15:0] rdata, mem_addr, mem_wdata;
  int checks = 0;
  int errors = 0;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done),
    .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata), .d_done(d_done),
    .rdata(rdata), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; i_req = 0; d_req = 0; d_wr = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; mem_rdata = 0;
    #3;
    checks++;
    if ({busy, mem_en, mem_wr, i_done, d_done, mem_addr, mem_wdata, rdata} !== 53'h0) begin
      errors++;
      $display("FAIL reset_outputs got %0h exp 0", {busy, mem_en, mem_wr, i_done, d_done, mem_addr, mem_wdata, rdata});
    end
    @(negedge clk) rst = 1'b1;
    tick;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle busy got %0b exp 0", busy); end
  endtask

  task automatic test_lone_i_read;
    i_req = 1; i_addr = 16'h0040;
    tick;
    checks++;
    if ({mem_en, mem_wr, busy, mem_addr} !== {3'b101, 16'h0040}) begin
      errors++;
      $display("FAIL lone_i_issue en/wr/busy/addr got %b%b%b %h exp 101 0040", mem_en, mem_wr, busy, mem_addr);
    end
    tick;
    checks++;
    if (mem_en !== 1'b0) begin errors++; $display("FAIL lone_i_wait mem_en got %b exp 0", mem_en); end
    mem_ready = 1; mem_rdata = 16'hBEEF;
    tick;
    checks++;
    if ({i_done, d_done, rdata} !== {2'b10, 16'hBEEF}) begin
      errors++;
      $display("FAIL lone_i_resp i_done/d_done/rdata got %b%b %h exp 10 beef", i_done, d_done, rdata);
    end
    i_req = 0; mem_ready = 0;
    tick;
    checks++;
    if ({i_done, d_done, busy} !== 3'b000) begin
      errors++;
      $display("FAIL lone_i_idle i_done/d_done/busy got %b%b%b exp 000", i_done, d_done, busy);
    end
  endtask

  task automatic test_d_write;
    d_req = 1; d_wr = 1; d_addr = 16'h1234; d_wdata = 16'hA5A5;
    tick;
    checks++;
    if ({mem_en, mem_wr, mem_addr, mem_wdata} !== {2'b11, 16'h1234, 16'hA5A5}) begin
      errors++;
      $display("FAIL d_write_issue en/wr/addr/wdata got %b%b %h %h exp 11 1234 a5a5", mem_en, mem_wr, mem_addr, mem_wdata);
    end
    tick;
    mem_ready = 1; mem_rdata = 16'h5A5A;
    tick;
    checks++;
    if ({d_done, i_done, rdata} !== {2'b10, 16'h5A5A}) begin
      errors++;
      $display("FAIL d_write_resp d_done/i_done/rdata got %b%b %h exp 10 5a5a", d_done, i_done, rdata);
    end
    d_req = 0; d_wr = 0; mem_ready = 0;
    tick;
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL d_write_single_pulse d_done got %b exp 0", d_done); end
  endtask

  task automatic test_simultaneous;
    logic [3:0] exp_d;
    logic [15:0] exp_addr;
    int i_pulses;
`ifdef MEM_ARB_RR_EN
    exp_d = 4'b0101;
`else
    exp_d = 4'b1111;
`endif
    i_pulses = 0;
    @(negedge clk) rst = 1'b0;
    @(negedge clk) rst = 1'b1;
    i_req = 1; d_req = 1; d_wr = 0; i_addr = 16'h0100; d_addr = 16'h0200;
    mem_ready = 1; mem_rdata = 16'h3C3C;
    for (int n = 0; n < 4; n++) begin
      tick;
      exp_addr = exp_d[n] ? 16'h0200 : 16'h0100;
      checks++;
      if ({mem_en, mem_addr} !== {1'b1, exp_addr}) begin
        errors++;
        $display("FAIL simul_grant%0d en/addr got %b %h exp 1 %h", n, mem_en, mem_addr, exp_addr);
      end
      tick;
      if (i_done) i_pulses++;
      checks++;
      if ({d_done, i_done} !== {exp_d[n], !exp_d[n]}) begin
        errors++;
        $display("FAIL simul_done%0d d/i got %b%b exp %b%b", n, d_done, i_done, exp_d[n], !exp_d[n]);
      end
      tick;
    end
    i_req = 0; d_req = 0; mem_ready = 0;
    tick;
`ifndef MEM_ARB_RR_EN
    checks++;
    if (i_pulses !== 0) begin errors++; $display("FAIL simul_fixed_i_done pulses got %0d exp 0", i_pulses); end
`endif
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL simul_end busy got %b exp 0", busy); end
  endtask

  task automatic test_delayed_ready;
    d_req = 1; d_wr = 0; d_addr = 16'h0300; d_wdata = 16'h0000;
    tick;
    d_addr = 16'hFFFF; d_wr = 1; d_wdata = 16'h9999;
    for (int c = 2; c <= 7; c++) begin
      tick;
      checks++;
      if ({busy, mem_en, d_done, mem_addr} !== {3'b100, 16'h0300}) begin
        errors++;
        $display("FAIL delayed_wait_c%0d busy/en/done/addr got %b%b%b %h exp 100 0300", c, busy, mem_en, d_done, mem_addr);
      end
      if (c == 7) begin mem_ready = 1; mem_rdata = 16'h0BAD; end
    end
    tick;
    checks++;
    if ({d_done, mem_wr, mem_addr, rdata} !== {2'b10, 16'h0300, 16'h0BAD}) begin
      errors++;
      $display("FAIL delayed_resp done/wr/addr/rdata got %b%b %h %h exp 10 0300 0bad", d_done, mem_wr, mem_addr, rdata);
    end
    d_req = 0; d_wr = 0; mem_ready = 0;
    tick;
  endtask

  task automatic test_reset_abort;
    d_req = 1; d_wr = 1; d_addr = 16'h0400; d_wdata = 16'h1111;
    tick;
    tick;
    d_req = 0; d_wr = 0; i_req = 1; i_addr = 16'h0050;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({busy, mem_en, mem_wr, i_done, d_done, mem_addr, mem_wdata, rdata} !== 53'h0) begin
      errors++;
      $display("FAIL abort_outputs got %0h exp 0", {busy, mem_en, mem_wr, i_done, d_done, mem_addr, mem_wdata, rdata});
    end
    @(negedge clk) rst = 1'b1;
    tick;
    checks++;
    if ({mem_en, mem_wr, d_done, mem_addr} !== {3'b100, 16'h0050}) begin
      errors++;
      $display("FAIL abort_first_grant en/wr/d_done/addr got %b%b%b %h exp 100 0050", mem_en, mem_wr, d_done, mem_addr);
    end
    tick;
    checks++;
    if (d_done !== 1'b0) begin errors++; $display("FAIL abort_no_done d_done got %b exp 0", d_done); end
    mem_ready = 1; mem_rdata = 16'h7777;
    tick;
    checks++;
    if ({i_done, d_done, rdata} !== {2'b10, 16'h7777}) begin
      errors++;
      $display("FAIL abort_resume i_done/d_done/rdata got %b%b %h exp 10 7777", i_done, d_done, rdata);
    end
    i_req = 0; mem_ready = 0;
    tick;
  endtask

  initial begin
    test_reset;
    test_lone_i_read;
    test_d_write;
    test_simultaneous;
    test_delayed_ready;
    test_reset_abort;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
